axi_write: RTL and testbench
============================

AXI_WRITE -- requirements
Module: axi_write

Interface
REQ-001 SHALL have parameter WR_FLIP_BYTE, default 0; 1 byte-reverses S_WR_tdata before it is written.
REQ-002 SHALL have parameter WR_ADDR_WIDTH, default 32; AXI address width.
REQ-003 SHALL have parameter WR_DATA_WIDTH, default 64; legal values are 32, 64 and 128.
REQ-004 SHALL have parameter WR_LIN, default 16; beats per burst, legal range 1-256.
REQ-005 SHALL have port S_WR_aclk, input, 1 bit; the single clock for all logic.
REQ-006 SHALL have port S_WR_aresetn, input, 1 bit; asynchronous active-low reset.
REQ-007 SHALL have port S_WR_tdata, input, WR_DATA_WIDTH; stream data in.
REQ-008 SHALL have port S_WR_tvalid, input, 1 bit; stream valid.
REQ-009 SHALL have port S_WR_tready, output, 1 bit; equals !fifo_full.
REQ-010 SHALL have port o_wr_done, output, 1 bit; 1-cycle pulse per completed burst, intended to drive the reader's i_wr_done.
REQ-011 SHALL have port o_wr_err, output, 1 bit; sticky bad-response flag.
REQ-012 SHALL have AW ports m_axi_awaddr (WR_ADDR_WIDTH), awlen (8), awsize (3), awburst (2), awvalid (out) and awready (in).
REQ-013 SHALL have W ports m_axi_wdata (WR_DATA_WIDTH), wstrb (WR_DATA_WIDTH/8, all ones), wlast, wvalid (out) and wready (in).
REQ-014 SHALL have B ports m_axi_bid (1), bresp (2), bvalid (in) and bready (out).
REQ-015 SHALL tie m_axi_awid=0, awlock=0, awcache=3, awprot=0 and awqos=0.

Function
REQ-016 SHALL buffer accepted beats (S_WR_tvalid && S_WR_tready) in a FIFO of depth 2*WR_LIN.
REQ-017 SHALL run FSM states IDLE, WR_ADDR, WR_DATA, WR_RESP and WR_DONE.
REQ-018 SHALL go IDLE->WR_ADDR when fifo_count >= WR_LIN, WR_ADDR->WR_DATA on awvalid&&awready, WR_DATA->WR_RESP on a wlast handshake, WR_RESP->WR_DONE on bvalid, and WR_DONE->IDLE unconditionally.
REQ-019 SHALL hold awvalid high only in WR_ADDR, with awaddr=wr_addr_buff, awlen=WR_LIN-1, awsize=clog2(WR_DATA_WIDTH/8) and awburst=INCR.
REQ-020 SHALL, in WR_DATA, drive wvalid=!fifo_empty and wdata=FIFO head, pop the FIFO only on wvalid&&wready, and hold wdata stable while wvalid && !wready.
REQ-021 SHALL use an 8-bit beat counter that is cleared on entry to WR_ADDR, and assert wlast when beat_cnt==WR_LIN-1 (WR_LIN=1: every beat is last).
REQ-022 SHALL assert bready only in WR_RESP.
REQ-023 SHALL pulse o_wr_done for exactly 1 cycle in WR_DONE.
REQ-024 SHALL, in WR_DONE, advance wr_addr_buff to 0 if it is >= 32'h10000-4096, else to wr_addr_buff+4096.
REQ-025 SHALL handle a simultaneous FIFO push and pop with count unchanged and no data loss, and SHALL keep accepting stream data in every FSM state while the FIFO is not full.
REQ-026 SHALL never issue a new AW before the previous B response completes (one outstanding burst).

Reset
REQ-027 SHALL, while S_WR_aresetn=0, drive FSM=IDLE, FIFO empty, wr_addr_buff=0, awvalid=wvalid=wlast=bready=0, o_wr_done=0, o_wr_err=0, S_WR_tready=0, and awaddr/awlen/awsize/awburst=0.
REQ-028 SHALL, on reset mid-burst, discard buffered data and partial burst state, and SHALL restart at address 0.

Configuration
REQ-029 SHALL, with AXI_WR_BRESP_CHK_EN defined, set o_wr_err on any bvalid with bresp!=2'b00 and hold it until reset.
REQ-030 SHALL, without AXI_WR_BRESP_CHK_EN, tie o_wr_err to 0 and ignore bresp; the port list is identical in both builds.

Structure
REQ-031 SHALL place the FSM state encoding, the AXI burst/resp constants and the 4096 / 32'h10000 address constants in shared package axi_rw_pkg.
REQ-032 SHALL implement the buffer as sub-module sync_fifo (parameters: width, depth; outputs: full, empty, count).

Verification
REQ-033 SHALL verify: WR_LIN=16, 64-bit, 16 beats 0..15 with wready=awready=1 -> one AW at 0x0 with awlen=15 and awsize=3, wlast on beat 15, o_wr_done 1 cycle after bvalid.
REQ-034 SHALL verify: 15 beats only -> no awvalid; a 16th beat -> awvalid within 2 cycles.
REQ-035 SHALL verify: wready toggling 1/0 per cycle -> wdata held during stalls, 16 handshakes, no duplicate or lost beat.
REQ-036 SHALL verify: 17 bursts back-to-back -> addresses 0x0, 0x1000 ... 0xF000, then 0x0.
REQ-037 SHALL verify: WR_FLIP_BYTE=1 with input 64'h0102030405060708 -> wdata 64'h0807060504030201.
REQ-038 SHALL verify: bresp=2'b10 -> o_wr_err=1 and sticky when AXI_WR_BRESP_CHK_EN is defined, 0 when it is undefined; reset asserted at beat 8 -> all outputs at reset values and the next burst at 0x0.

Source files
------------

// File: rtl/axi_rw_pkg.sv
// Shared definitions for the AXI stream-to-memory write path: FSM state
// encoding, AXI burst/response constants and the address window constants.
package axi_rw_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_RESP = 3'd3,
        WR_DONE = 3'd4
    } wr_state_e;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

    // Each burst lands in its own 4 KiB slot; slots wrap inside a 64 KiB window.
    localparam logic [31:0] AXI_ADDR_STEP  = 32'd4096;
    localparam logic [31:0] AXI_ADDR_WRAP  = 32'h10000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Depth need not be a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array: written on every accepted push, no reset needed.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_write.sv
// Stream-to-AXI4 burst writer. Buffers stream beats and emits one INCR burst
// of WR_LIN beats at a time into successive 4 KiB slots of a 64 KiB window.
// Optional macro AXI_WR_BRESP_CHK_EN: enables the sticky bad-BRESP flag.
module axi_write
    import axi_rw_pkg::*;
#(
    parameter int unsigned WR_FLIP_BYTE  = 0,
    parameter int unsigned WR_ADDR_WIDTH = 32,
    parameter int unsigned WR_DATA_WIDTH = 64,
    parameter int unsigned WR_LIN        = 16
) (
    input  logic                       S_WR_aclk,
    input  logic                       S_WR_aresetn,
    input  logic [WR_DATA_WIDTH-1:0]   S_WR_tdata,
    input  logic                       S_WR_tvalid,
    output logic                       S_WR_tready,
    output logic                       o_wr_done,
    output logic                       o_wr_err,
    output logic                       m_axi_awid,
    output logic [WR_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                 m_axi_awlen,
    output logic [2:0]                 m_axi_awsize,
    output logic [1:0]                 m_axi_awburst,
    output logic                       m_axi_awlock,
    output logic [3:0]                 m_axi_awcache,
    output logic [2:0]                 m_axi_awprot,
    output logic [3:0]                 m_axi_awqos,
    output logic                       m_axi_awvalid,
    input  logic                       m_axi_awready,
    output logic [WR_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [WR_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                       m_axi_wlast,
    output logic                       m_axi_wvalid,
    input  logic                       m_axi_wready,
    input  logic                       m_axi_bid,
    input  logic [1:0]                 m_axi_bresp,
    input  logic                       m_axi_bvalid,
    output logic                       m_axi_bready
);

    localparam int unsigned NBYTES     = WR_DATA_WIDTH / 8;
    localparam int unsigned FIFO_DEPTH = 2 * WR_LIN;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [7:0]  AW_LEN     = 8'(WR_LIN - 1);
    localparam logic [2:0]  AW_SIZE    = 3'($clog2(NBYTES));
    localparam logic [WR_ADDR_WIDTH-1:0] ADDR_LIMIT  = WR_ADDR_WIDTH'(AXI_ADDR_WRAP - AXI_ADDR_STEP);
    localparam logic [WR_ADDR_WIDTH-1:0] ADDR_STEP_W = WR_ADDR_WIDTH'(AXI_ADDR_STEP);

    wr_state_e                state;
    logic [WR_ADDR_WIDTH-1:0] wr_addr_buff;
    logic [7:0]               beat_cnt;
    logic [WR_DATA_WIDTH-1:0] push_data;
    logic [WR_DATA_WIDTH-1:0] fifo_head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CNT_W-1:0]         fifo_count;
    logic                     push;
    logic                     w_hs;

    assign m_axi_awid    = 1'b0;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'd3;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_awqos   = 4'd0;
    assign m_axi_wstrb   = '1;

    // Gate with reset so the stream side sees not-ready while reset is held.
    assign S_WR_tready  = S_WR_aresetn && !fifo_full;
    assign push         = S_WR_tvalid && S_WR_tready;
    assign m_axi_wvalid = (state == WR_DATA) && !fifo_empty;
    assign m_axi_wdata  = fifo_head;
    assign m_axi_wlast  = (state == WR_DATA) && (beat_cnt == AW_LEN);
    assign w_hs         = m_axi_wvalid && m_axi_wready;

    generate
        if (WR_FLIP_BYTE != 0) begin : g_flip
            // Byte-reverse each incoming word before it enters the buffer.
            always_comb begin
                push_data = '0;
                for (int unsigned i = 0; i < NBYTES; i++) begin
                    push_data[8*i +: 8] = S_WR_tdata[8*(NBYTES-1-i) +: 8];
                end
            end
        end else begin : g_pass
            assign push_data = S_WR_tdata;
        end
    endgenerate

    sync_fifo #(
        .WIDTH (WR_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .i_clk   (S_WR_aclk),
        .i_rst_n (S_WR_aresetn),
        .wr_en   (push),
        .wr_data (push_data),
        .rd_en   (w_hs),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Burst sequencer: one outstanding burst, AW and B-channel outputs registered.
    always_ff @(posedge S_WR_aclk or negedge S_WR_aresetn) begin
        if (!S_WR_aresetn) begin
            state         <= IDLE;
            wr_addr_buff  <= '0;
            beat_cnt      <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awlen   <= '0;
            m_axi_awsize  <= '0;
            m_axi_awburst <= '0;
            m_axi_bready  <= 1'b0;
            o_wr_done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_count >= CNT_W'(WR_LIN)) begin
                        state         <= WR_ADDR;
                        beat_cnt      <= '0;
                        m_axi_awvalid <= 1'b1;
                        m_axi_awaddr  <= wr_addr_buff;
                        m_axi_awlen   <= AW_LEN;
                        m_axi_awsize  <= AW_SIZE;
                        m_axi_awburst <= AXI_BURST_INCR;
                    end
                end
                WR_ADDR: begin
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        state         <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (m_axi_wlast) begin
                            m_axi_bready <= 1'b1;
                            state        <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        o_wr_done    <= 1'b1;
                        state        <= WR_DONE;
                    end
                end
                WR_DONE: begin
                    o_wr_done    <= 1'b0;
                    wr_addr_buff <= (wr_addr_buff >= ADDR_LIMIT) ? '0 : wr_addr_buff + ADDR_STEP_W;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXI_WR_BRESP_CHK_EN
    logic unused_bid;
    assign unused_bid = m_axi_bid;

    // Sticky error: any non-OKAY write response latches until reset.
    always_ff @(posedge S_WR_aclk or negedge S_WR_aresetn) begin
        if (!S_WR_aresetn) begin
            o_wr_err <= 1'b0;
        end else if (m_axi_bvalid && (m_axi_bresp != AXI_RESP_OKAY)) begin
            o_wr_err <= 1'b1;
        end
    end
`else
    logic unused_b;
    assign unused_b = ^{m_axi_bid, m_axi_bresp};
    assign o_wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_write.sv
// Bench for axi_write: queue-based reference model, vector table, hand sequences.
module tb_axi_write;

`ifdef AXI_WR_BRESP_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        awready = 1'b1;
    logic        wready = 1'b1;
    logic        bid = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;

    logic        tready, wr_done, wr_err, awid, awlock, awvalid, wlast, wvalid, bready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst;
    logic [3:0]  awcache, awqos;
    logic [63:0] wdata;
    logic [7:0]  wstrb;

    logic        f_tready, f_wr_done, f_wr_err, f_awid, f_awlock, f_awvalid, f_wlast, f_wvalid, f_bready;
    logic [31:0] f_awaddr;
    logic [7:0]  f_awlen;
    logic [2:0]  f_awsize, f_awprot;
    logic [1:0]  f_awburst;
    logic [3:0]  f_awcache, f_awqos;
    logic [63:0] f_wdata;
    logic [7:0]  f_wstrb;

    always #5 clk = ~clk;

    axi_write #(.WR_FLIP_BYTE(0), .WR_ADDR_WIDTH(32), .WR_DATA_WIDTH(64), .WR_LIN(16)) dut (
        .S_WR_aclk(clk), .S_WR_aresetn(rst_n), .S_WR_tdata(tdata), .S_WR_tvalid(tvalid),
        .S_WR_tready(tready), .o_wr_done(wr_done), .o_wr_err(wr_err),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache), .m_axi_awprot(awprot),
        .m_axi_awqos(awqos), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready)
    );

    axi_write #(.WR_FLIP_BYTE(1), .WR_ADDR_WIDTH(32), .WR_DATA_WIDTH(64), .WR_LIN(16)) dut_f (
        .S_WR_aclk(clk), .S_WR_aresetn(rst_n), .S_WR_tdata(tdata), .S_WR_tvalid(tvalid),
        .S_WR_tready(f_tready), .o_wr_done(f_wr_done), .o_wr_err(f_wr_err),
        .m_axi_awid(f_awid), .m_axi_awaddr(f_awaddr), .m_axi_awlen(f_awlen), .m_axi_awsize(f_awsize),
        .m_axi_awburst(f_awburst), .m_axi_awlock(f_awlock), .m_axi_awcache(f_awcache), .m_axi_awprot(f_awprot),
        .m_axi_awqos(f_awqos), .m_axi_awvalid(f_awvalid), .m_axi_awready(awready),
        .m_axi_wdata(f_wdata), .m_axi_wstrb(f_wstrb), .m_axi_wlast(f_wlast), .m_axi_wvalid(f_wvalid),
        .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
        .m_axi_bready(f_bready)
    );

    int checks = 0;
    int fails  = 0;

    // Reference model state
    logic [63:0] q[$];
    int          burst_idx = 0;
    int          beat_in_burst = 0;
    int          b_cnt = 0;
    int          w_total = 0;
    bit          outstanding = 1'b0;
    bit          b_hs_prev = 1'b0;
    bit          err_model = 1'b0;
    bit          stall_prev = 1'b0;
    logic [63:0] held = '0;
    logic [63:0] first_f_wdata = '0;
    bit          mon_en = 1'b0;
    bit          b_pending = 1'b0;
    bit          b_hs_flag = 1'b0;
    logic [1:0]  cur_bresp = 2'b00;
    int          wr_mode = 0;
    int          aw_mode = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] flip64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
        return r;
    endfunction

    // Monitor: samples on the falling edge, i.e. the values the next rising edge will see.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("tready", tready, q.size() < 32);
            chk("wr_done", wr_done, b_hs_prev);
            chk("wr_err", wr_err, err_model);
            b_hs_prev = 1'b0;
            if (stall_prev && wvalid) chk("wdata_hold", wdata, held);
            stall_prev = wvalid && !wready;
            held = wdata;
            if (awvalid && awready) begin
                chk("aw_one_outstanding", outstanding, 0);
                chk("awaddr", awaddr, (burst_idx % 16) * 4096);
                chk("awlen", awlen, 15);
                chk("awsize", awsize, 3);
                chk("awburst", awburst, 1);
                outstanding = 1'b1;
                beat_in_burst = 0;
            end
            if (wvalid && wready) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL w_beat: got %h expected none (queue empty)", wdata);
                end else begin
                    logic [63:0] e;
                    e = q.pop_front();
                    chk("wdata", wdata, e);
                    chk("wdata_flip", f_wdata, flip64(e));
                    chk("wlast", wlast, beat_in_burst == 15);
                    if (beat_in_burst == 0) first_f_wdata = f_wdata;
                    if (beat_in_burst == 15) b_pending = 1'b1;
                    beat_in_burst++;
                    w_total++;
                end
            end
            if (bvalid && bready) begin
                b_hs_prev = 1'b1;
                b_hs_flag = 1'b1;
                b_cnt++;
                burst_idx++;
                outstanding = 1'b0;
                if (ERR_EN && bresp != 2'b00) err_model = 1'b1;
            end
            if (tvalid && tready) q.push_back(tdata);
        end
    end

    // Slave-side responders for W ready, AW ready and the B channel.
    always @(posedge clk) begin
        #1;
        case (wr_mode)
            0:       wready = 1'b1;
            1:       wready = !wready;
            2:       wready = 1'($urandom_range(0, 1));
            default: wready = 1'b0;
        endcase
        awready = (aw_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (!rst_n) begin
            bvalid = 1'b0;
        end else if (b_hs_flag) begin
            bvalid = 1'b0;
            b_hs_flag = 1'b0;
        end else if (b_pending) begin
            bvalid = 1'b1;
            bresp = cur_bresp;
            b_pending = 1'b0;
        end
    end

    task automatic send(input logic [63:0] d);
        bit ok = 1'b0;
        tdata = d;
        tvalid = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (tready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: got tready=0 expected 1 within 2000 cycles");
        end
    endtask

    task automatic wait_bursts(input int target);
        int n = 0;
        while (b_cnt < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("burst_count", b_cnt, target);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_awvalid"}, awvalid, 0);
        chk({tag, "_wvalid"}, wvalid, 0);
        chk({tag, "_wlast"}, wlast, 0);
        chk({tag, "_bready"}, bready, 0);
        chk({tag, "_wr_done"}, wr_done, 0);
        chk({tag, "_wr_err"}, wr_err, 0);
        chk({tag, "_tready"}, tready, 0);
        chk({tag, "_awaddr"}, awaddr, 0);
        chk({tag, "_awlen"}, awlen, 0);
        chk({tag, "_awsize"}, awsize, 0);
        chk({tag, "_awburst"}, awburst, 0);
        chk({tag, "_awcache"}, awcache, 3);
        chk({tag, "_awid"}, awid, 0);
        chk({tag, "_wstrb"}, wstrb, 8'hFF);
    endtask

    task automatic clear_model();
        q.delete();
        burst_idx = 0;
        beat_in_burst = 0;
        outstanding = 1'b0;
        err_model = 1'b0;
        b_pending = 1'b0;
        b_hs_flag = 1'b0;
        b_hs_prev = 1'b0;
        stall_prev = 1'b0;
        bvalid = 1'b0;
    endtask

    typedef struct {
        int         n_bursts;
        int         wmode;
        int         amode;
        logic [1:0] resp;
        bit         rand_data;
        bit         err_if_chk;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int          lat;
        bit          aw_seen;
        logic [63:0] seq;
        int          target;
        int          n;

        vecs[0] = '{n_bursts: 1,  wmode: 1, amode: 0, resp: 2'b00, rand_data: 0, err_if_chk: 0};
        vecs[1] = '{n_bursts: 2,  wmode: 2, amode: 2, resp: 2'b00, rand_data: 1, err_if_chk: 0};
        vecs[2] = '{n_bursts: 1,  wmode: 0, amode: 0, resp: 2'b10, rand_data: 1, err_if_chk: 1};
        vecs[3] = '{n_bursts: 1,  wmode: 2, amode: 0, resp: 2'b00, rand_data: 1, err_if_chk: 1};
        vecs[4] = '{n_bursts: 11, wmode: 2, amode: 2, resp: 2'b00, rand_data: 1, err_if_chk: 1};

        // Reset values
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // 15 beats: no burst yet
        for (int i = 0; i < 15; i++) send(64'(i));
        aw_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (awvalid) aw_seen = 1'b1;
        end
        chk("no_aw_at_15", aw_seen, 0);
        @(posedge clk);
        #1;
        // 16th beat triggers AW within 2 cycles
        send(64'd15);
        lat = 0;
        for (int i = 1; i <= 4 && lat == 0; i++) begin
            @(negedge clk);
            if (awvalid) lat = i;
        end
        chk("aw_latency_le2", (lat >= 1) && (lat <= 2), 1);
        @(posedge clk);
        #1;
        wait_bursts(1);
        chk("first_drain", q.size(), 0);

        // Vector table
        seq = 64'h100;
        foreach (vecs[k]) begin
            wr_mode = vecs[k].wmode;
            aw_mode = vecs[k].amode;
            cur_bresp = vecs[k].resp;
            target = b_cnt + vecs[k].n_bursts;
            for (int i = 0; i < vecs[k].n_bursts * 16; i++) begin
                if (vecs[k].rand_data) send({$urandom, $urandom});
                else begin
                    send(seq);
                    seq++;
                end
            end
            wait_bursts(target);
            chk("vec_err", wr_err, ERR_EN && vecs[k].err_if_chk);
            chk("vec_drain", q.size(), 0);
            chk("vec_wvalid_idle", wvalid, 0);
        end
        chk("wrapped_burst_idx", burst_idx, 17);

        // Byte flip
        wr_mode = 0;
        aw_mode = 0;
        cur_bresp = 2'b00;
        target = b_cnt + 1;
        send(64'h0102030405060708);
        for (int i = 1; i < 16; i++) send(64'(i));
        wait_bursts(target);
        chk("flip_first_word", first_f_wdata, 64'h0807060504030201);

        // Reset at beat 8 of a burst
        target = w_total + 8;
        for (int i = 0; i < 16; i++) send(64'hA000 + 64'(i));
        n = 0;
        while (w_total < target && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("beat8_reached", w_total >= target, 1);
        #1;
        rst_n = 1'b0;
        clear_model();
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        target = b_cnt + 1;
        for (int i = 0; i < 16; i++) send(64'hB000 + 64'(i));
        wait_bursts(target);
        chk("post_reset_burst_idx", burst_idx, 1);
        chk("post_reset_err", wr_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
